// File: rtl/dsp_acc_pkg.sv
// Shared defaults and FSM state encoding for the product accumulator.
package dsp_acc_pkg;

  localparam int DEF_P_WIDTH   = 65;
  localparam int DEF_ACC_WIDTH = 72;
  localparam int DEF_COUNT     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_STALL = 2'd2
  } acc_state_t;

endpackage

// File: rtl/dsp_acc_out_reg.sv
// Single-entry valid/ready result register; data and overflow stay put while
// valid is high and the consumer is not ready.
module dsp_acc_out_reg #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         load_ovf,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic         out_ovf,
  output logic         out_vld
);

  logic [W-1:0] dat_q, dat_d;
  logic         ovf_q, ovf_d;
  logic         vld_q, vld_d;

  // The upstream only asserts load when the slot is empty or draining this edge.
  always_comb begin
    dat_d = dat_q;
    ovf_d = ovf_q;
    vld_d = vld_q;
    if (load) begin
      dat_d = load_dat;
      ovf_d = load_ovf;
      vld_d = 1'b1;
    end else if (vld_q && out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_q <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      ovf_q <= ovf_d;
      vld_q <= vld_d;
    end
  end

  assign out_dat = dat_q;
  assign out_ovf = ovf_q;
  assign out_vld = vld_q;

endmodule

// File: rtl/dsp_product_accumulator.sv
// Sums COUNT unsigned products per window with saturation and a sticky overflow
// flag; the window result appears one cycle after the final beat.
module dsp_product_accumulator
  import dsp_acc_pkg::*;
#(
  parameter int P_WIDTH   = DEF_P_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int COUNT     = DEF_COUNT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [P_WIDTH-1:0]   p_in,
  input  logic                 p_valid,
  output logic                 p_ready,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 acc_ovf,
  output logic                 acc_valid,
  input  logic                 acc_ready
);

  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic [CNT_W-1:0]     count_q, count_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic                 sticky_q, sticky_d;
  acc_state_t           state_q, state_d;

  logic                 at_last, beat, load;
  logic [ACC_WIDTH-1:0] base, add_sat;
  logic [ACC_WIDTH:0]   add_full;
  logic                 carry;

  assign at_last = (count_q == LAST);
  // Only the final beat needs the output slot, so stall just that one.
  assign p_ready = !reset && !(at_last && acc_valid && !acc_ready);
  assign beat    = p_valid && p_ready;
  assign load    = beat && at_last && !clear;

  assign base     = (state_q == ST_IDLE) ? '0 : sum_q;
  assign add_full = {1'b0, base} + (ACC_WIDTH + 1)'(p_in);
  assign carry    = add_full[ACC_WIDTH];
  assign add_sat  = carry ? '1 : add_full[ACC_WIDTH-1:0];

  always_comb begin
    count_d  = count_q;
    sum_d    = sum_q;
    sticky_d = sticky_q;
    state_d  = state_q;
    if (clear) begin
      count_d  = '0;
      sum_d    = '0;
      sticky_d = 1'b0;
      state_d  = ST_IDLE;
    end else if (beat) begin
      if (at_last) begin
        count_d  = '0;
        sum_d    = '0;
        sticky_d = 1'b0;
        state_d  = ST_IDLE;
      end else begin
        count_d  = count_q + CNT_W'(1);
        sum_d    = add_sat;
        sticky_d = sticky_q | carry;
        state_d  = ST_ACCUM;
      end
    end else if (state_q != ST_IDLE) begin
      state_d = p_ready ? ST_ACCUM : ST_STALL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      sum_q    <= '0;
      sticky_q <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      count_q  <= count_d;
      sum_q    <= sum_d;
      sticky_q <= sticky_d;
      state_q  <= state_d;
    end
  end

  dsp_acc_out_reg #(.W(ACC_WIDTH)) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_dat (add_sat),
    .load_ovf (sticky_q | carry),
    .out_rdy  (acc_ready),
    .out_dat  (acc_out),
    .out_ovf  (acc_ovf),
    .out_vld  (acc_valid)
  );

endmodule

// File: tb/tb_dsp_product_accumulator.sv
// Directed bench: a 65/72-bit COUNT=4 instance and an 8/8-bit COUNT=4 instance
// for saturation, sharing clock and reset.
module tb_dsp_product_accumulator;

  logic        clk = 1'b0;
  logic        reset;

  logic [64:0] p_in;
  logic        p_valid, p_ready, clear;
  logic [71:0] acc_out;
  logic        acc_ovf, acc_valid, acc_ready;

  logic [7:0]  p_in8;
  logic        p_valid8, p_ready8, clear8;
  logic [7:0]  acc_out8;
  logic        acc_ovf8, acc_valid8, acc_ready8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dsp_product_accumulator #(.P_WIDTH(65), .ACC_WIDTH(72), .COUNT(4)) dut (
    .clk(clk), .reset(reset), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready),
    .clear(clear), .acc_out(acc_out), .acc_ovf(acc_ovf), .acc_valid(acc_valid),
    .acc_ready(acc_ready)
  );

  dsp_product_accumulator #(.P_WIDTH(8), .ACC_WIDTH(8), .COUNT(4)) dut8 (
    .clk(clk), .reset(reset), .p_in(p_in8), .p_valid(p_valid8), .p_ready(p_ready8),
    .clear(clear8), .acc_out(acc_out8), .acc_ovf(acc_ovf8), .acc_valid(acc_valid8),
    .acc_ready(acc_ready8)
  );

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int v);
    p_valid = 1'b1;
    p_in    = 65'(v);
    tick();
  endtask

  task automatic beat8(input int v);
    p_valid8 = 1'b1;
    p_in8    = 8'(v);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    p_in = '0; p_valid = 1'b0; clear = 1'b0; acc_ready = 1'b0;
    p_in8 = '0; p_valid8 = 1'b0; clear8 = 1'b0; acc_ready8 = 1'b0;
    #1;
    chk("rst_acc_out", acc_out, 72'd0);
    chk("rst_acc_valid", 72'(acc_valid), 72'd0);
    chk("rst_acc_ovf", 72'(acc_ovf), 72'd0);
    chk("rst_p_ready", 72'(p_ready), 72'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_p_ready", 72'(p_ready), 72'd1);

    // Basic window 5+10+3+2, result exactly one cycle after the last beat.
    acc_ready = 1'b1;
    beat(5); beat(10); beat(3);
    chk("w1_not_early", 72'(acc_valid), 72'd0);
    beat(2);
    p_valid = 1'b0;
    chk("w1_valid", 72'(acc_valid), 72'd1);
    chk("w1_sum", acc_out, 72'd20);
    chk("w1_ovf", 72'(acc_ovf), 72'd0);
    tick();
    chk("w1_drained", 72'(acc_valid), 72'd0);

    // Back-to-back windows with p_valid held high.
    for (int i = 0; i < 8; i++) begin
      p_valid = 1'b1;
      p_in    = (i < 4) ? 65'd1 : 65'd2;
      #1;
      chk($sformatf("b2b_p_ready_%0d", i), 72'(p_ready), 72'd1);
      tick();
      if (i == 3) begin
        chk("b2b_sum4_valid", 72'(acc_valid), 72'd1);
        chk("b2b_sum4", acc_out, 72'd4);
      end
      if (i == 4) chk("b2b_gap_consumed", 72'(acc_valid), 72'd0);
    end
    p_valid = 1'b0;
    chk("b2b_sum8_valid", 72'(acc_valid), 72'd1);
    chk("b2b_sum8", acc_out, 72'd8);
    tick();

    // Consumer stall: result 4 held while next window reaches count 3.
    acc_ready = 1'b0;
    beat(1); beat(1); beat(1); beat(1);
    chk("stall_first_valid", 72'(acc_valid), 72'd1);
    chk("stall_first_sum", acc_out, 72'd4);
    beat(2); beat(2); beat(2);
    p_valid = 1'b1; p_in = 65'd2;
    #1;
    chk("stall_p_ready_low", 72'(p_ready), 72'd0);
    tick();
    chk("stall_hold_sum", acc_out, 72'd4);
    chk("stall_hold_valid", 72'(acc_valid), 72'd1);
    chk("stall_still_low", 72'(p_ready), 72'd0);
    acc_ready = 1'b1;
    #1;
    chk("stall_release_p_ready", 72'(p_ready), 72'd1);
    tick();
    p_valid = 1'b0;
    chk("stall_new_valid", 72'(acc_valid), 72'd1);
    chk("stall_new_sum", acc_out, 72'd8);
    tick();
    chk("stall_drained", 72'(acc_valid), 72'd0);

    // Saturation on the 8-bit instance, then a clean window.
    acc_ready8 = 1'b1;
    beat8(255); beat8(255); beat8(255); beat8(255);
    p_valid8 = 1'b0;
    chk("sat_valid", 72'(acc_valid8), 72'd1);
    chk("sat_sum", 72'(acc_out8), 72'd255);
    chk("sat_ovf", 72'(acc_ovf8), 72'd1);
    beat8(1); beat8(1); beat8(1); beat8(1);
    p_valid8 = 1'b0;
    chk("sat_next_sum", 72'(acc_out8), 72'd4);
    chk("sat_next_ovf", 72'(acc_ovf8), 72'd0);
    tick();

    // Clear discards a partial window.
    beat(7); beat(7);
    p_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    beat(1); beat(2); beat(3); beat(4);
    p_valid = 1'b0;
    chk("clr_sum", acc_out, 72'd10);
    chk("clr_valid", 72'(acc_valid), 72'd1);
    tick();

    // Clear coinciding with a beat drops that beat.
    beat(1); beat(1);
    clear = 1'b1;
    beat(100);
    clear = 1'b0;
    beat(1); beat(2); beat(3);
    p_valid = 1'b0;
    chk("clr_beat_no_early", 72'(acc_valid), 72'd0);
    beat(4);
    p_valid = 1'b0;
    chk("clr_beat_sum", acc_out, 72'd10);
    tick();

    // Reset mid-window with a result pending.
    acc_ready = 1'b0;
    beat(1); beat(1); beat(1); beat(1);
    beat(5); beat(5);
    p_valid = 1'b0;
    chk("prerst_valid", 72'(acc_valid), 72'd1);
    reset = 1'b1;
    #1;
    chk("midrst_acc_out", acc_out, 72'd0);
    chk("midrst_acc_valid", 72'(acc_valid), 72'd0);
    chk("midrst_acc_ovf", 72'(acc_ovf), 72'd0);
    chk("midrst_p_ready", 72'(p_ready), 72'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_release_p_ready", 72'(p_ready), 72'd1);
    acc_ready = 1'b1;
    beat(1); beat(2); beat(3); beat(4);
    p_valid = 1'b0;
    chk("midrst_new_sum", acc_out, 72'd10);
    chk("midrst_new_valid", 72'(acc_valid), 72'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dsp_product_accumulator.md
DSP_PRODUCT_ACCUMULATOR -- requirements
Module: dsp_product_accumulator

Interface
REQ-001 SHALL have parameter P_WIDTH, default 65, width of the incoming unsigned product from dsp_mul_parameterized.
REQ-002 SHALL have parameter ACC_WIDTH, default 72, accumulator and result width; ACC_WIDTH >= P_WIDTH.
REQ-003 SHALL have parameter COUNT, default 8, products per accumulation window; legal range 2..256.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port p_in  input  P_WIDTH  unsigned product operand.
REQ-007 SHALL have port p_valid  input  1  p_in valid this cycle.
REQ-008 SHALL have port p_ready  output  1  block can accept p_in this cycle.
REQ-009 SHALL have port clear  input  1  synchronous discard of the partial window.
REQ-010 SHALL have port acc_out  output  ACC_WIDTH  completed window sum.
REQ-011 SHALL have port acc_ovf  output  1  saturation occurred in the window reported on acc_out.
REQ-012 SHALL have port acc_valid  output  1  acc_out/acc_ovf valid.
REQ-013 SHALL have port acc_ready  input  1  consumer accepts acc_out this cycle.

Function
REQ-014 SHALL accept a product only when p_valid && p_ready on a rising edge (a "beat").
REQ-015 SHALL zero-extend p_in to ACC_WIDTH and add it to the running sum on each beat.
REQ-016 SHALL saturate the running sum at 2^ACC_WIDTH-1 on carry-out and set a per-window sticky overflow bit.
REQ-017 SHALL keep a beat counter 0..COUNT-1 that wraps to 0 on the COUNT-th beat.
REQ-018 SHALL, on the COUNT-th beat, load sum+p_in (saturated) into acc_out, the sticky bit (or new overflow) into acc_ovf, and assert acc_valid the next cycle: latency 1 cycle from final beat.
REQ-019 SHALL restart the running sum and sticky bit at 0 on the COUNT-th beat, so a new window may begin the following cycle with no bubble.
REQ-020 SHALL hold acc_out, acc_ovf, acc_valid stable while acc_valid && !acc_ready.
REQ-021 SHALL deassert acc_valid the cycle after acc_valid && acc_ready unless a new result is loaded on the same edge.
REQ-022 SHALL drive p_ready = !(count==COUNT-1 && acc_valid && !acc_ready); the acc_ready-to-p_ready combinational path is permitted.
REQ-023 SHALL, when the final beat and acc_ready handshake coincide, load the new result and keep acc_valid high.
REQ-024 SHALL implement states IDLE (count 0, sum 0), ACCUM (partial window), STALL (count==COUNT-1, output occupied, acc_ready low); IDLE->ACCUM on first beat, ACCUM->IDLE on COUNT-th beat, ACCUM->STALL when the p_ready condition drops, STALL->ACCUM when acc_ready rises.
REQ-025 SHALL on clear reset count, sum, sticky bit to 0 and go to IDLE; a p_in beat in the same cycle is dropped; a pending acc_out is unaffected.
REQ-026 SHALL ignore p_in when p_valid is low; acc_ready while acc_valid low has no effect.

Reset
REQ-027 SHALL on reset assertion immediately force acc_out=0, acc_ovf=0, acc_valid=0, count=0, sum=0, state IDLE.
REQ-028 SHALL drive p_ready=0 while reset is asserted and 1 in the first cycle after release.
REQ-029 SHALL discard any partial window and any unconsumed result on reset mid-operation.

Structure
REQ-030 SHALL place default widths/COUNT and the IDLE/ACCUM/STALL state enum in package dsp_acc_pkg.
REQ-031 SHALL instantiate one sub-module dsp_acc_out_reg: single-entry valid/ready output register holding acc_out and acc_ovf.
REQ-032 SHALL fit in 120-400 lines of RTL, no vendor primitives other than inferred adders.

Verification
REQ-033 SHALL test COUNT=4, beats 5,10,3,2 with acc_ready=1 -> acc_out=20, acc_ovf=0, acc_valid high exactly 1 cycle after the 4th beat.
REQ-034 SHALL test back-to-back windows 1,1,1,1 then 2,2,2,2 with p_valid continuously high -> results 4 then 8, no gap, p_ready always 1.
REQ-035 SHALL test acc_ready=0 holding result 4 while a second window reaches 3 beats -> p_ready=0 at count 3, acc_out stays 4; raise acc_ready -> 4th beat accepted same cycle, next acc_out=8.
REQ-036 SHALL test ACC_WIDTH=P_WIDTH=8, four beats of 255 -> acc_out=255, acc_ovf=1; next window 1,1,1,1 -> acc_out=4, acc_ovf=0.
REQ-037 SHALL test clear after beats 7,7 then beats 1,2,3,4 -> acc_out=10; clear coinciding with a beat drops that beat.
REQ-038 SHALL test reset asserted mid-window and with acc_valid=1 -> all outputs 0 asynchronously, p_ready=1 one cycle after release, next window sums from 0.
